// File: rtl/id_ex_if.sv
// ID/EX boundary bundle: decoded instruction from ID, registered copy to EX,
// plus the flush/stall controls and the hazard flags returned upstream.
interface id_ex_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              id_valid;
    logic [XLEN-1:0]   id_pc, id_pc4, id_rd1, id_rd2, id_imm;
    logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
    logic              id_memory_we, id_reg_we, id_memory_read, id_slt, id_lui;
    logic [2:0]        id_ex;
    logic [1:0]        id_jump_t, id_branch_t;
    logic              flush_e, stall_e;

    logic              ex_valid;
    logic [XLEN-1:0]   ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_rd;
    logic              ex_memory_we, ex_reg_we, ex_memory_read, ex_slt, ex_lui;
    logic [2:0]        ex_ex;
    logic [1:0]        ex_jump_t, ex_branch_t;
    logic              load_use, stall_fd;

    modport master (
        output id_valid, id_pc, id_pc4, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_memory_we, id_reg_we, id_memory_read, id_slt, id_lui, id_ex,
               id_jump_t, id_branch_t, flush_e, stall_e,
        input  ex_valid, ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_memory_we, ex_reg_we, ex_memory_read, ex_slt, ex_lui, ex_ex,
               ex_jump_t, ex_branch_t, load_use, stall_fd
    );

    modport slave (
        input  id_valid, id_pc, id_pc4, id_rd1, id_rd2, id_imm, id_rs1, id_rs2, id_rd,
               id_memory_we, id_reg_we, id_memory_read, id_slt, id_lui, id_ex,
               id_jump_t, id_branch_t, flush_e, stall_e,
        output ex_valid, ex_pc, ex_pc4, ex_rd1, ex_rd2, ex_imm, ex_rs1, ex_rs2, ex_rd,
               ex_memory_we, ex_reg_we, ex_memory_read, ex_slt, ex_lui, ex_ex,
               ex_jump_t, ex_branch_t, load_use, stall_fd
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use detection, bubble insertion, flush and stall hold.
// Optional IDEX_BUBBLE_CNT_EN adds bubble_cnt / flush_cnt event counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    id_ex_if.slave      bus
`ifdef IDEX_BUBBLE_CNT_EN
    ,
    output logic [31:0] bubble_cnt,
    output logic [31:0] flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              memory_we;
        logic              reg_we;
        logic              memory_read;
        logic              slt;
        logic              lui;
        logic [2:0]        ex;
        logic [1:0]        jump_t;
        logic [1:0]        branch_t;
    } ex_bundle_t;

    localparam int BW = $bits(ex_bundle_t);

    ex_bundle_t r_ex;
    ex_bundle_t w_id_bundle;
    logic       w_use1;
    logic       w_use2;
    logic       w_load_use;

    // Hazard detect: LUI and JAL read no source registers, and x0 never hazards.
    always_comb begin
        w_use1     = ~bus.id_lui & (bus.id_jump_t != 2'b01);
        w_use2     = w_use1;
        w_load_use = bus.id_valid & r_ex.valid & r_ex.memory_read
                   & (r_ex.rd != {REG_AW{1'b0}})
                   & ((w_use1 & (r_ex.rd == bus.id_rs1)) | (w_use2 & (r_ex.rd == bus.id_rs2)));
    end

    // Next-stage bundle from ID; an invalid slot keeps its data but loses all control.
    always_comb begin
        w_id_bundle       = ex_bundle_t'({BW{1'b0}});
        w_id_bundle.valid = bus.id_valid;
        w_id_bundle.pc    = bus.id_pc;
        w_id_bundle.pc4   = bus.id_pc4;
        w_id_bundle.rd1   = bus.id_rd1;
        w_id_bundle.rd2   = bus.id_rd2;
        w_id_bundle.imm   = bus.id_imm;
        w_id_bundle.rs1   = bus.id_rs1;
        w_id_bundle.rs2   = bus.id_rs2;
        w_id_bundle.rd    = bus.id_rd;
        if (bus.id_valid) begin
            w_id_bundle.memory_we   = bus.id_memory_we;
            w_id_bundle.reg_we      = bus.id_reg_we;
            w_id_bundle.memory_read = bus.id_memory_read;
            w_id_bundle.slt         = bus.id_slt;
            w_id_bundle.lui         = bus.id_lui;
            w_id_bundle.ex          = bus.id_ex;
            w_id_bundle.jump_t      = bus.id_jump_t;
            w_id_bundle.branch_t    = bus.id_branch_t;
        end else begin
            w_id_bundle.memory_we   = 1'b0;
            w_id_bundle.reg_we      = 1'b0;
            w_id_bundle.memory_read = 1'b0;
            w_id_bundle.slt         = 1'b0;
            w_id_bundle.lui         = 1'b0;
            w_id_bundle.ex          = 3'd0;
            w_id_bundle.jump_t      = 2'b00;
            w_id_bundle.branch_t    = 2'b00;
        end
    end

    // Pipeline register: flush beats stall, stall beats load-use bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex <= ex_bundle_t'({BW{1'b0}});
        end else if (bus.flush_e) begin
            r_ex <= ex_bundle_t'({BW{1'b0}});
        end else if (bus.stall_e) begin
            r_ex <= r_ex;
        end else if (w_load_use) begin
            r_ex <= ex_bundle_t'({BW{1'b0}});
        end else begin
            r_ex <= w_id_bundle;
        end
    end

    assign bus.load_use       = w_load_use;
    assign bus.stall_fd       = (w_load_use | bus.stall_e) & ~bus.flush_e;
    assign bus.ex_valid       = r_ex.valid;
    assign bus.ex_pc          = r_ex.pc;
    assign bus.ex_pc4         = r_ex.pc4;
    assign bus.ex_rd1         = r_ex.rd1;
    assign bus.ex_rd2         = r_ex.rd2;
    assign bus.ex_imm         = r_ex.imm;
    assign bus.ex_rs1         = r_ex.rs1;
    assign bus.ex_rs2         = r_ex.rs2;
    assign bus.ex_rd          = r_ex.rd;
    assign bus.ex_memory_we   = r_ex.memory_we;
    assign bus.ex_reg_we      = r_ex.reg_we;
    assign bus.ex_memory_read = r_ex.memory_read;
    assign bus.ex_slt         = r_ex.slt;
    assign bus.ex_lui         = r_ex.lui;
    assign bus.ex_ex          = r_ex.ex;
    assign bus.ex_jump_t      = r_ex.jump_t;
    assign bus.ex_branch_t    = r_ex.branch_t;

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] r_bubble_cnt;
    logic [31:0] r_flush_cnt;

    // Event counters; a flush bubble is never also counted as a load-use bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= 32'd0;
            r_flush_cnt  <= 32'd0;
        end else if (bus.flush_e) begin
            r_bubble_cnt <= r_bubble_cnt;
            r_flush_cnt  <= r_flush_cnt + 32'd1;
        end else if (!bus.stall_e && w_load_use) begin
            r_bubble_cnt <= r_bubble_cnt + 32'd1;
            r_flush_cnt  <= r_flush_cnt;
        end else begin
            r_bubble_cnt <= r_bubble_cnt;
            r_flush_cnt  <= r_flush_cnt;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
    assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

    localparam int EW = 188;

    typedef struct packed {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        mwe, rwe, mrd, slt, lui;
        logic [2:0]  ex;
        logic [1:0]  jt, bt;
    } instr_t;

    typedef struct {
        int            cyc;
        logic [EW-1:0] ex;
        logic          lu, sfd, cc;
        logic [31:0]   eb, ef;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   passed = 0;
    int   cyc = 0;
    rec_t q[$];

    id_ex_if #(.XLEN(32), .REG_AW(5)) bus();

`ifdef IDEX_BUBBLE_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus),
                                            .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt));
`else
    id_ex_stage #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    always #5 clk = ~clk;

    function automatic instr_t mk(input logic [31:0] pc, imm, input logic [4:0] rs1, rs2, rd,
                                  input logic mwe, rwe, mrd, slt, lui,
                                  input logic [2:0] ex, input logic [1:0] jt, bt);
        instr_t i;
        i.pc = pc; i.imm = imm; i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
        i.rd1 = pc ^ 32'hA5A5_0000; i.rd2 = pc ^ 32'h5A5A_0000;
        i.mwe = mwe; i.rwe = rwe; i.mrd = mrd; i.slt = slt; i.lui = lui;
        i.ex = ex; i.jt = jt; i.bt = bt;
        return i;
    endfunction

    // What EX must show after this instruction is loaded with the given valid bit.
    function automatic logic [EW-1:0] exp_of(input instr_t i, input logic v);
        logic [11:0] ctrl;
        ctrl = v ? {i.mwe, i.rwe, i.mrd, i.slt, i.lui, i.ex, i.jt, i.bt} : 12'd0;
        return {v, i.pc, i.pc + 32'd4, i.rd1, i.rd2, i.imm, i.rs1, i.rs2, i.rd, ctrl};
    endfunction

    function automatic logic [EW-1:0] act_ex();
        return {bus.ex_valid, bus.ex_pc, bus.ex_pc4, bus.ex_rd1, bus.ex_rd2, bus.ex_imm,
                bus.ex_rs1, bus.ex_rs2, bus.ex_rd, bus.ex_memory_we, bus.ex_reg_we,
                bus.ex_memory_read, bus.ex_slt, bus.ex_lui, bus.ex_ex, bus.ex_jump_t,
                bus.ex_branch_t};
    endfunction

    task automatic check(input string nm, input int c, input logic [EW-1:0] act, exp);
        total++;
        if (act !== exp) $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, exp);
        else passed++;
    endtask

    task automatic step(input instr_t in, input logic v, fl, st, rn,
                        input logic [EW-1:0] e, input logic lu, sfd,
                        input logic cc = 1'b0, input logic [31:0] eb = 32'd0, ef = 32'd0);
        rec_t r;
        @(posedge clk);
        #1;
        rst_n              = rn;
        bus.id_valid       = v;
        bus.id_pc          = in.pc;
        bus.id_pc4         = in.pc + 32'd4;
        bus.id_rd1         = in.rd1;
        bus.id_rd2         = in.rd2;
        bus.id_imm         = in.imm;
        bus.id_rs1         = in.rs1;
        bus.id_rs2         = in.rs2;
        bus.id_rd          = in.rd;
        bus.id_memory_we   = in.mwe;
        bus.id_reg_we      = in.rwe;
        bus.id_memory_read = in.mrd;
        bus.id_slt         = in.slt;
        bus.id_lui         = in.lui;
        bus.id_ex          = in.ex;
        bus.id_jump_t      = in.jt;
        bus.id_branch_t    = in.bt;
        bus.flush_e        = fl;
        bus.stall_e        = st;
        r.cyc = cyc; r.ex = e; r.lu = lu; r.sfd = sfd; r.cc = cc; r.eb = eb; r.ef = ef;
        q.push_back(r);
        cyc++;
    endtask

    // Monitor: one expectation per cycle, sampled mid-cycle.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                r = q.pop_front();
                check("ex_bundle", r.cyc, act_ex(), r.ex);
                check("load_use", r.cyc, {{(EW-1){1'b0}}, bus.load_use}, {{(EW-1){1'b0}}, r.lu});
                check("stall_fd", r.cyc, {{(EW-1){1'b0}}, bus.stall_fd}, {{(EW-1){1'b0}}, r.sfd});
`ifdef IDEX_BUBBLE_CNT_EN
                if (r.cc) begin
                    check("bubble_cnt", r.cyc, {{(EW-32){1'b0}}, bubble_cnt}, {{(EW-32){1'b0}}, r.eb});
                    check("flush_cnt", r.cyc, {{(EW-32){1'b0}}, flush_cnt}, {{(EW-32){1'b0}}, r.ef});
                end
`endif
            end
        end
    end

    initial begin
        instr_t a, lw, add7, lw0, addx0, lw3, lui3, br, jal;
        logic [EW-1:0] z;
        z     = {EW{1'b0}};
        a     = mk(32'h100, 32'h10,       5'd1, 5'd2, 5'd5,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 2'b00, 2'b00);
        lw    = mk(32'h104, 32'h4,        5'd2, 5'd0, 5'd7,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
        add7  = mk(32'h108, 32'h0,        5'd7, 5'd8, 5'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
        lw0   = mk(32'h10C, 32'h8,        5'd3, 5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
        addx0 = mk(32'h110, 32'h0,        5'd0, 5'd0, 5'd10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
        lw3   = mk(32'h114, 32'hC,        5'd4, 5'd0, 5'd3,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 2'b00, 2'b00);
        lui3  = mk(32'h118, 32'h12345000, 5'd3, 5'd3, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 2'b00, 2'b00);
        br    = mk(32'h11C, 32'hFFFFFFF0, 5'd6, 5'd7, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 2'b11, 2'b01);
        jal   = mk(32'h120, 32'h40,       5'd7, 5'd7, 5'd1,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 2'b01, 2'b00);
        bus.flush_e = 1'b0;
        bus.stall_e = 1'b0;

        step(a,     1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0);                 // reset held
        step(a,     1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0);                 // release
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(a, 1'b1), 1'b0, 1'b0);
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b1, 1'b1);  // load-use rs1
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0);
        step(lw0,   1'b1, 1'b0, 1'b0, 1'b1, exp_of(add7, 1'b1), 1'b0, 1'b0);
        step(addx0, 1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw0, 1'b1), 1'b0, 1'b0); // rd = x0
        step(lw3,   1'b1, 1'b0, 1'b0, 1'b1, exp_of(addx0, 1'b1), 1'b0, 1'b0);
        step(lui3,  1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw3, 1'b1), 1'b0, 1'b0); // LUI exempt
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(lui3, 1'b1), 1'b0, 1'b0);
        step(add7,  1'b1, 1'b1, 1'b1, 1'b1, exp_of(lw, 1'b1), 1'b1, 1'b0);  // flush+stall+lu
        step(br,    1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0);
        step(a,     1'b1, 1'b0, 1'b1, 1'b1, exp_of(br, 1'b1), 1'b0, 1'b1);  // stall x3
        step(lw,    1'b1, 1'b0, 1'b1, 1'b1, exp_of(br, 1'b1), 1'b0, 1'b1);
        step(add7,  1'b1, 1'b0, 1'b1, 1'b1, exp_of(br, 1'b1), 1'b0, 1'b1);
        step(a,     1'b0, 1'b0, 1'b0, 1'b1, exp_of(br, 1'b1), 1'b0, 1'b0);  // invalid ID
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(a, 1'b0), 1'b0, 1'b0);
        step(add7,  1'b0, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b0, 1'b0);
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(add7, 1'b0), 1'b0, 1'b0);
        step(br,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b1, 1'b1);  // load-use rs2
        step(br,    1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0, 1'b1, 32'd2, 32'd1);
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(br, 1'b1), 1'b0, 1'b0);
        step(jal,   1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b0, 1'b0);  // JAL exempt
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(jal, 1'b1), 1'b0, 1'b0);
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b1, 1'b1);
        step(add7,  1'b1, 1'b0, 1'b0, 1'b0, z, 1'b0, 1'b0);                 // reset mid-flow
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0);
        step(a,     1'b1, 1'b0, 1'b0, 1'b1, exp_of(add7, 1'b1), 1'b0, 1'b0);
        step(lw,    1'b1, 1'b0, 1'b0, 1'b1, exp_of(a, 1'b1), 1'b0, 1'b0);
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, exp_of(lw, 1'b1), 1'b1, 1'b1);
`ifdef IDEX_BUBBLE_CNT_EN
        #2 force dut.r_bubble_cnt = 32'hFFFF_FFFF;
        #1 release dut.r_bubble_cnt;
`endif
        step(add7,  1'b1, 1'b0, 1'b0, 1'b1, z, 1'b0, 1'b0, 1'b1, 32'd0, 32'd0); // wrap
        step(a,     1'b1, 1'b0, 1'b0, 1'b1, exp_of(add7, 1'b1), 1'b0, 1'b0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
